// File: rtl/vblank_access_scheduler_if.sv
// Request/grant bundle between game-logic updaters and the vblank scheduler.
// Latency: none, wires only; grant is registered inside the scheduler.
// Backpressure: req is a held level, done is a one-cycle pulse from the granted requester.
interface vblank_access_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;

  // requester side
  modport master (output req, output done, input grant);
  // scheduler side
  modport slave (input req, input done, output grant);
endinterface

// File: rtl/vblank_access_scheduler.sv
// Round-robin owner of the vertical-blanking update window; one grant per requester per frame.
// Latency: grant registered 1 cycle after an eligible req in ARB; next grant 2 cycles after done.
// Backpressure: req held until served; grant ends on done, window close, or (VBLANK_SCHED_WATCHDOG_EN) watchdog.
module vblank_access_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int COUNT_W      = 16,
  parameter int VBLANK_START = 515,
  parameter int VBLANK_END   = 35,
  parameter int MAX_HOLD     = 255
) (
  input  logic                     clk_25MHz,
  input  logic                     reset,
  input  logic [COUNT_W-1:0]       pixelX,
  input  logic [COUNT_W-1:0]       pixelY,
  vblank_access_scheduler_if.slave bus,
  output logic                     frameStart,
  output logic                     windowOpen,
  output logic [NUM_REQ-1:0]       servedMask,
  output logic                     overrun,
  output logic                     timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(NUM_REQ - 1);
  // Hold counter stops at the watchdog limit; beyond it the value carries no information.
  localparam logic [COUNT_W-1:0] HOLD_CAP = COUNT_W'(MAX_HOLD);
`ifdef VBLANK_SCHED_WATCHDOG_EN
  localparam logic [COUNT_W-1:0] HOLD_LAST = COUNT_W'(MAX_HOLD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   g_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               pick_vld;
  logic [COUNT_W-1:0] hold_cnt;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] eligible;
  logic               open_ev;
  logic               close_ev;
  logic               done_g;

  assign open_ev   = (pixelY == COUNT_W'(VBLANK_START)) && (pixelX == '0);
  assign close_ev  = (pixelY == COUNT_W'(VBLANK_END)) && (pixelX == '0);
  assign eligible  = bus.req & ~servedMask;
  assign done_g    = bus.done[g_idx];
  assign bus.grant = grant_q;

`ifndef VBLANK_SCHED_WATCHDOG_EN
  assign timeout = 1'b0;
`endif

  // Round-robin pick: first eligible bit searching upward from rr_ptr+1 with wrap.
  // Loop runs from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (eligible[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Window/arbitration FSM with all outputs registered.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= RR_INIT;
      g_idx      <= '0;
      hold_cnt   <= '0;
      grant_q    <= '0;
      frameStart <= 1'b0;
      windowOpen <= 1'b0;
      servedMask <= '0;
      overrun    <= 1'b0;
`ifdef VBLANK_SCHED_WATCHDOG_EN
      timeout    <= 1'b0;
`endif
    end else begin
      frameStart <= 1'b0;
      overrun    <= 1'b0;
`ifdef VBLANK_SCHED_WATCHDOG_EN
      timeout    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          grant_q <= '0;
          if (open_ev) begin
            frameStart <= 1'b1;
            windowOpen <= 1'b1;
            servedMask <= '0;
            state      <= ARB;
          end
        end

        ARB: begin
          // Window close wins over any pending grant.
          if (close_ev) begin
            windowOpen <= 1'b0;
            state      <= IDLE;
          end else if (pick_vld) begin
            grant_q  <= NUM_REQ'(1) << pick_idx;
            g_idx    <= pick_idx;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end

        GRANT: begin
          if (done_g) begin
            // Completion is honoured even when it coincides with close.
            grant_q            <= '0;
            servedMask[g_idx]  <= 1'b1;
            rr_ptr             <= g_idx;
            if (close_ev) begin
              windowOpen <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= ARB;
            end
          end else if (close_ev) begin
            // Unfinished update: revoke, flag it, leave it unserved for debug.
            grant_q    <= '0;
            overrun    <= 1'b1;
            rr_ptr     <= g_idx;
            windowOpen <= 1'b0;
            state      <= IDLE;
`ifdef VBLANK_SCHED_WATCHDOG_EN
          end else if (hold_cnt == HOLD_LAST) begin
            // Stuck requester: revoke and mark served so it is not retried this frame.
            grant_q           <= '0;
            timeout           <= 1'b1;
            servedMask[g_idx] <= 1'b1;
            rr_ptr            <= g_idx;
            state             <= ARB;
`endif
          end else if (hold_cnt != HOLD_CAP) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          grant_q <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vblank_access_scheduler.md
Name: vblank_access_scheduler

Overview:
- Round-robin scheduler that shares the vertical-blanking update window between game-logic requesters (paddle, ball, score and similar updaters).
- Watches pixelX/pixelY from the 640x480 sync counters and opens a window once per frame while no pixels are drawn.
- Grants exclusive access to one requester at a time, so game state changes only while the screen is blanked.
- Each requester is served at most once per frame.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
COUNT_W, 16, width of pixelX/pixelY inputs
VBLANK_START, 515, pixelY value whose pixelX==0 opens the window
VBLANK_END, 35, pixelY value whose pixelX==0 closes the window
MAX_HOLD, 255, watchdog limit in cycles per grant (used only with the optional feature)

Ports:
clk_25MHz  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-high
pixelX  in  COUNT_W  horizontal counter, 0..799
pixelY  in  COUNT_W  vertical counter, 0..524
req  in  NUM_REQ  level request per requester
done  in  NUM_REQ  1-cycle completion pulse from the granted requester
grant  out  NUM_REQ  one-hot or zero, registered
frameStart  out  1  1-cycle pulse when the window opens
windowOpen  out  1  high from window open to window close
servedMask  out  NUM_REQ  requesters already served this frame
overrun  out  1  1-cycle pulse: a grant was revoked by window close
timeout  out  1  1-cycle pulse: a grant was revoked by the watchdog

Behaviour:
- Reset values: all outputs 0, state IDLE, rrPtr = NUM_REQ-1 (req[0] has first priority), holdCnt = 0.
- Events, decoded combinationally from inputs:
  - openEv = (pixelY==VBLANK_START && pixelX==0)
  - closeEv = (pixelY==VBLANK_END && pixelX==0)
- IDLE:
  - grant = 0, windowOpen = 0.
  - On openEv: next cycle frameStart=1, windowOpen=1, servedMask=0; go to ARB.
  - closeEv is ignored in IDLE.
- ARB:
  - eligible = req & ~servedMask.
  - If closeEv: windowOpen=0; go to IDLE. This has priority over granting.
  - Else if eligible is nonzero: pick the first set bit searching upward from rrPtr+1 with wrap; grant that one-hot the next cycle; go to GRANT; holdCnt=0.
  - Else stay in ARB.
  - Latency: req rising while in ARB gives grant 1 cycle later.
- GRANT (granted index g):
  - done[g]=1: servedMask[g]=1, rrPtr=g, grant=0 next cycle, go to ARB. The earliest next grant is 2 cycles after done.
  - done[g]=1 together with closeEv in the same cycle: done is honoured (served set, no overrun), then go to IDLE.
  - closeEv without done[g]: grant=0, overrun pulse, servedMask[g] stays 0, rrPtr=g; go to IDLE.
  - done on a non-granted bit is ignored in every state.
  - req[g] dropping while granted does not revoke the grant; only done, closeEv or the watchdog ends it.
- openEv outside IDLE is ignored: one window per frame.
- servedMask holds its value after close until the next openEv, so software/debug can read it during active video.
- holdCnt: COUNT_W bits, increments every cycle in GRANT, saturates, cleared on entry to GRANT.
- Reset mid-grant: grant drops on the cycle after reset is sampled; all state returns to reset values.

Optional Feature:
- Macro: VBLANK_SCHED_WATCHDOG_EN.
- Defined: in GRANT, when holdCnt == MAX_HOLD-1 without done, revoke the grant next cycle, pulse timeout, set servedMask[g]=1 (no retry this frame), rrPtr=g, go to ARB.
- Not defined: watchdog logic is removed; timeout is tied to 0; a grant ends only on done or closeEv.

Test Plan:
- Reset, then sweep counters to pixelY=515, pixelX=0 -> frameStart pulses one cycle later; windowOpen=1; servedMask=0; grant=0.
- req=4'b1111, each requester pulses done 3 cycles after its grant -> grants in order 0001, 0010, 0100, 1000; servedMask ends at 1111; no further grants until the next frame.
- req=4'b0101 held across two frames, rrPtr=0 after frame 1 -> frame 2 serves bit 2 then bit 0.
- Granted requester never pulses done, watchdog disabled -> grant held until pixelY=35, pixelX=0; overrun pulses; grant=0 the next cycle; windowOpen=0.
- done[g] in the same cycle as closeEv -> servedMask[g]=1, overrun stays 0, state returns to IDLE.
- With VBLANK_SCHED_WATCHDOG_EN and MAX_HOLD=10, no done -> grant high exactly 10 cycles; timeout pulses; next eligible requester granted 1 cycle after revoke; the stuck requester is marked served.
